xctcmsg_bus_arbiter: RTL and testbench

Shared message-bus controller connecting the bus send/receive ports of `NUM_HARTS` xctcmsg units. It picks one pending sender per grant using round-robin, latches the message into a single-entry transfer register, and routes it to the destination hart's receive port. Invalid destinations are dropped and flagged. It sits between the per-hart `bus_*` ports and replaces point-to-point wiring in multi-hart configurations.

---
 rtl/xctcmsg_bus_arbiter.sv | 117 +++++++++++
 tb/tb_xctcmsg_bus_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/xctcmsg_bus_arbiter.sv
// Shared message bus between NUM_HARTS xctcmsg units.
// A round-robin grant feeds a single-entry transfer register, which is then
// delivered to the destination hart. Messages addressed to a nonexistent hart
// are dropped and flagged with a one-cycle error pulse.
module xctcmsg_bus_arbiter #(
    parameter int NUM_HARTS = 4,
    parameter int IDX_W     = $clog2(NUM_HARTS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_HARTS-1:0]       snd_val_i,
    output logic [NUM_HARTS-1:0]       snd_ack_o,
    input  logic [NUM_HARTS-1:0][31:0] snd_dst_i,
    input  logic [NUM_HARTS-1:0][31:0] snd_tag_i,
    input  logic [NUM_HARTS-1:0][63:0] snd_msg_i,
    output logic [NUM_HARTS-1:0]       rcv_val_o,
    input  logic [NUM_HARTS-1:0]       rcv_rdy_i,
    output logic [31:0]                rcv_src_o,
    output logic [31:0]                rcv_tag_o,
    output logic [63:0]                rcv_msg_o,
    output logic                       err_o,
    output logic [31:0]                msg_count_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_HARTS - 1);
    localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

    // Transfer register and control state
    logic             full_p1;
    logic [IDX_W-1:0] src_p1;
    logic [IDX_W-1:0] dst_p1;
    logic [31:0]      tag_p1;
    logic [63:0]      msg_p1;
    logic             err_p1;
    logic [31:0]      msg_count;
    logic [IDX_W-1:0] rr_ptr;

    logic             found;
    logic [IDX_W-1:0] winner;
    logic             dlv_hs;
    logic             grant;
    logic             dst_ok;

    // Round-robin search: first requester at or above rr_ptr, wrapping around
    always_comb begin
        int idx;
        idx    = 0;
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NUM_HARTS; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_HARTS) begin
                idx = idx - NUM_HARTS;
            end
            if (!found && snd_val_i[idx]) begin
                found  = 1'b1;
                winner = IDX_W'(idx);
            end
        end
    end

    // Delivery handshake, grant bypass and destination range check
    always_comb begin
        dlv_hs = full_p1 && rcv_rdy_i[dst_p1];
        // Holding ack low under reset keeps every output at its reset value.
        grant  = rst_n && found && (!full_p1 || dlv_hs);
        dst_ok = snd_dst_i[winner] < 32'(NUM_HARTS);
    end

    // One-hot ack toward the winner and receive-valid toward the stored destination
    always_comb begin
        snd_ack_o = '0;
        rcv_val_o = '0;
        for (int h = 0; h < NUM_HARTS; h++) begin
            snd_ack_o[h] = grant && (winner == IDX_W'(h));
            rcv_val_o[h] = full_p1 && (dst_p1 == IDX_W'(h));
        end
    end

    // Transfer register, round-robin pointer, error pulse and delivery counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_p1   <= 1'b0;
            src_p1    <= '0;
            dst_p1    <= '0;
            tag_p1    <= '0;
            msg_p1    <= '0;
            err_p1    <= 1'b0;
            msg_count <= '0;
            rr_ptr    <= '0;
        end else begin
            err_p1 <= grant && !dst_ok;
            if (dlv_hs) begin
                msg_count <= msg_count + 32'd1;
            end
            if (grant) begin
                // An invalid message is still captured but never marked full,
                // so the data outputs change while rcv_val_o stays low.
                full_p1 <= dst_ok;
                src_p1  <= winner;
                dst_p1  <= snd_dst_i[winner][IDX_W-1:0];
                tag_p1  <= snd_tag_i[winner];
                msg_p1  <= snd_msg_i[winner];
                rr_ptr  <= (winner == LAST_IDX) ? '0 : winner + ONE_IDX;
            end else if (dlv_hs) begin
                full_p1 <= 1'b0;
            end
        end
    end

    assign rcv_src_o   = 32'(src_p1);
    assign rcv_tag_o   = tag_p1;
    assign rcv_msg_o   = msg_p1;
    assign err_o       = err_p1;
    assign msg_count_o = msg_count;

endmodule

// File: tb/tb_xctcmsg_bus_arbiter.sv
// Directed testbench for xctcmsg_bus_arbiter (NUM_HARTS = 4).
// Each table row is one clock cycle: inputs are driven at the falling edge and
// the outputs are checked 1 ns later, reflecting the state after the previous
// rising edge plus the combinational ack for the current inputs.
module tb_xctcmsg_bus_arbiter;

    localparam int NH = 4;

    logic                clk;
    logic                rst_n;
    logic [NH-1:0]       snd_val;
    logic [NH-1:0]       snd_ack;
    logic [NH-1:0][31:0] snd_dst;
    logic [NH-1:0][31:0] snd_tag;
    logic [NH-1:0][63:0] snd_msg;
    logic [NH-1:0]       rcv_val;
    logic [NH-1:0]       rcv_rdy;
    logic [31:0]         rcv_src;
    logic [31:0]         rcv_tag;
    logic [63:0]         rcv_msg;
    logic                err;
    logic [31:0]         msg_count;

    int total = 0;
    int bad   = 0;

    xctcmsg_bus_arbiter #(.NUM_HARTS(NH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .snd_val_i   (snd_val),
        .snd_ack_o   (snd_ack),
        .snd_dst_i   (snd_dst),
        .snd_tag_i   (snd_tag),
        .snd_msg_i   (snd_msg),
        .rcv_val_o   (rcv_val),
        .rcv_rdy_i   (rcv_rdy),
        .rcv_src_o   (rcv_src),
        .rcv_tag_o   (rcv_tag),
        .rcv_msg_o   (rcv_msg),
        .err_o       (err),
        .msg_count_o (msg_count)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0]       val;
        logic [3:0]       rdy;
        logic [3:0][31:0] dst;
        logic [3:0]       ack;
        logic [3:0]       rval;
        logic [31:0]      src;
        logic             err;
        logic [31:0]      cnt;
    } vec_t;

    localparam int NV = 30;
    vec_t tbl [NV];

    function automatic vec_t mk(input logic [3:0] val, input logic [3:0] rdy,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic [31:0] d2, input logic [31:0] d3,
                                input logic [3:0] ack, input logic [3:0] rval,
                                input logic [31:0] src, input logic e,
                                input logic [31:0] cnt);
        vec_t v;
        v.val    = val;
        v.rdy    = rdy;
        v.dst[0] = d0;
        v.dst[1] = d1;
        v.dst[2] = d2;
        v.dst[3] = d3;
        v.ack    = ack;
        v.rval   = rval;
        v.src    = src;
        v.err    = e;
        v.cnt    = cnt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_zero_outputs(input string nm);
        chk({nm, " ack"}, 64'(snd_ack), 64'd0);
        chk({nm, " rval"}, 64'(rcv_val), 64'd0);
        chk({nm, " src"}, 64'(rcv_src), 64'd0);
        chk({nm, " tag"}, 64'(rcv_tag), 64'd0);
        chk({nm, " msg"}, rcv_msg, 64'd0);
        chk({nm, " err"}, 64'(err), 64'd0);
        chk({nm, " cnt"}, 64'(msg_count), 64'd0);
    endtask

    initial begin
        // Single send: hart 1 -> hart 2
        tbl[0]  = mk(4'b0010, 4'b1111, 0, 2, 0, 0, 4'b0010, 4'b0000, 0, 0, 0);
        tbl[1]  = mk(4'b0000, 4'b1111, 0, 0, 0, 0, 4'b0000, 4'b0100, 1, 0, 0);
        tbl[2]  = mk(4'b0000, 4'b1111, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 1);
        // Round robin among harts 0, 1, 3 starting from rr_ptr = 2
        tbl[3]  = mk(4'b1011, 4'b1111, 1, 2, 0, 0, 4'b1000, 4'b0000, 0, 0, 1);
        tbl[4]  = mk(4'b1011, 4'b1111, 1, 2, 0, 0, 4'b0001, 4'b0001, 3, 0, 1);
        tbl[5]  = mk(4'b1011, 4'b1111, 1, 2, 0, 0, 4'b0010, 4'b0010, 0, 0, 2);
        tbl[6]  = mk(4'b1011, 4'b1111, 1, 2, 0, 0, 4'b1000, 4'b0100, 1, 0, 3);
        tbl[7]  = mk(4'b1011, 4'b1111, 1, 2, 0, 0, 4'b0001, 4'b0001, 3, 0, 4);
        tbl[8]  = mk(4'b1011, 4'b1111, 1, 2, 0, 0, 4'b0010, 4'b0010, 0, 0, 5);
        tbl[9]  = mk(4'b0000, 4'b1111, 0, 0, 0, 0, 4'b0000, 4'b0100, 1, 0, 6);
        tbl[10] = mk(4'b0000, 4'b1111, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 7);
        // Backpressure: hart 3 not ready, harts 0 and 2 both target hart 3
        tbl[11] = mk(4'b0101, 4'b0111, 3, 0, 3, 0, 4'b0100, 4'b0000, 0, 0, 7);
        for (int i = 12; i <= 16; i++) begin
            tbl[i] = mk(4'b0001, 4'b0111, 3, 0, 0, 0, 4'b0000, 4'b1000, 2, 0, 7);
        end
        tbl[17] = mk(4'b0001, 4'b1111, 3, 0, 0, 0, 4'b0001, 4'b1000, 2, 0, 7);
        tbl[18] = mk(4'b0000, 4'b1111, 0, 0, 0, 0, 4'b0000, 4'b1000, 0, 0, 8);
        tbl[19] = mk(4'b0000, 4'b1111, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 9);
        // Invalid destinations from hart 2: dst = NUM_HARTS, then upper bits set
        tbl[20] = mk(4'b0100, 4'b1111, 0, 0, 4, 0, 4'b0100, 4'b0000, 0, 0, 9);
        tbl[21] = mk(4'b0000, 4'b1111, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 1, 9);
        tbl[22] = mk(4'b0100, 4'b1111, 0, 0, 32'h8000_0001, 0, 4'b0100, 4'b0000, 0, 0, 9);
        tbl[23] = mk(4'b0000, 4'b1111, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 1, 9);
        tbl[24] = mk(4'b0000, 4'b1111, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 9);
        // Self-send, back-to-back, hart 0 -> hart 0 three times
        tbl[25] = mk(4'b0001, 4'b1111, 0, 0, 0, 0, 4'b0001, 4'b0000, 0, 0, 9);
        tbl[26] = mk(4'b0001, 4'b1111, 0, 0, 0, 0, 4'b0001, 4'b0001, 0, 0, 9);
        tbl[27] = mk(4'b0001, 4'b1111, 0, 0, 0, 0, 4'b0001, 4'b0001, 0, 0, 10);
        tbl[28] = mk(4'b0000, 4'b1111, 0, 0, 0, 0, 4'b0000, 4'b0001, 0, 0, 11);
        tbl[29] = mk(4'b0000, 4'b1111, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 12);

        for (int h = 0; h < NH; h++) begin
            snd_tag[h] = 32'h100 + 32'(h);
            snd_msg[h] = 64'hCAFE_0000_0000_0000 + 64'(h);
            snd_dst[h] = '0;
        end
        snd_val = '0;
        rcv_rdy = '1;
        rst_n   = 1'b0;

        // Reset state
        #1;
        chk_zero_outputs("reset");
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            snd_val = tbl[i].val;
            rcv_rdy = tbl[i].rdy;
            for (int h = 0; h < NH; h++) begin
                snd_dst[h] = tbl[i].dst[h];
            end
            #1;
            chk($sformatf("row%0d ack", i), 64'(snd_ack), 64'(tbl[i].ack));
            chk($sformatf("row%0d rval", i), 64'(rcv_val), 64'(tbl[i].rval));
            chk($sformatf("row%0d err", i), 64'(err), 64'(tbl[i].err));
            chk($sformatf("row%0d cnt", i), 64'(msg_count), 64'(tbl[i].cnt));
            if (tbl[i].rval != 4'b0000) begin
                chk($sformatf("row%0d src", i), 64'(rcv_src), 64'(tbl[i].src));
                chk($sformatf("row%0d tag", i), 64'(rcv_tag), 64'(32'h100 + tbl[i].src));
                chk($sformatf("row%0d msg", i), rcv_msg, 64'hCAFE_0000_0000_0000 + 64'(tbl[i].src));
            end
        end

        // Reset mid-delivery: hart 1 -> hart 2 while hart 2 is stalled
        @(negedge clk);
        snd_val    = 4'b0010;
        snd_dst[1] = 32'd2;
        rcv_rdy    = 4'b1011;
        #1;
        chk("mid ack", 64'(snd_ack), 64'b0010);
        @(negedge clk);
        snd_val = 4'b0000;
        #1;
        chk("mid rval", 64'(rcv_val), 64'b0100);
        chk("mid src", 64'(rcv_src), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("async reset");
        // A 0/1 tie presented during reset must not be acked
        snd_val    = 4'b0011;
        snd_dst[0] = 32'd1;
        snd_dst[1] = 32'd0;
        rcv_rdy    = 4'b1111;
        #1;
        chk("reset ack", 64'(snd_ack), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post ack tie", 64'(snd_ack), 64'b0001);
        chk("post rval", 64'(rcv_val), 64'd0);
        @(negedge clk);
        snd_val = 4'b0000;
        #1;
        chk("post dlv rval", 64'(rcv_val), 64'b0010);
        chk("post dlv src", 64'(rcv_src), 64'd0);
        chk("post dlv tag", 64'(rcv_tag), 64'h100);
        chk("post dlv cnt", 64'(msg_count), 64'd0);
        @(negedge clk);
        #1;
        chk("post final rval", 64'(rcv_val), 64'd0);
        chk("post final cnt", 64'(msg_count), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
